// File: rtl/axis_pixels_sched_if.sv
// Descriptor, DMA pixel and shifter-side streams of the pixel-input layer sequencer.
// The slave modport is the sequencer's view and the master modport is the surrounding logic's view.
interface axis_pixels_sched_if #(
  parameter int S_WIDTH        = 128,
  parameter int WORD_WIDTH     = 8,
  parameter int BITS_KH2       = 2,
  parameter int BITS_CI        = 10,
  parameter int BITS_XW        = 9,
  parameter int BITS_IM_BLOCKS = 5,
  parameter int BITS_BEATS     = 20
);
  logic                           cfg_valid;
  logic                           cfg_ready;
  logic [BITS_KH2-1:0]            cfg_kh2;
  logic [BITS_CI-1:0]             cfg_ci;
  logic [BITS_XW-1:0]             cfg_w;
  logic [BITS_IM_BLOCKS-1:0]      cfg_l;
  logic [BITS_BEATS-1:0]          cfg_beats;
  logic                           px_valid;
  logic                           px_ready;
  logic                           px_last;
  logic [S_WIDTH-1:0]             px_data;
  logic [S_WIDTH/WORD_WIDTH-1:0]  px_keep;
  logic                           m_valid;
  logic                           m_ready;
  logic                           m_last;
  logic [S_WIDTH-1:0]             m_data;
  logic [S_WIDTH/WORD_WIDTH-1:0]  m_keep;
  logic                           done;
  logic                           busy;
  logic                           err_last;
  logic [15:0]                    layers_done;

  modport slave (
    input  cfg_valid, cfg_kh2, cfg_ci, cfg_w, cfg_l, cfg_beats,
    input  px_valid, px_last, px_data, px_keep, m_ready, done,
    output cfg_ready, px_ready, m_valid, m_last, m_data, m_keep,
    output busy, err_last, layers_done
  );

  modport master (
    output cfg_valid, cfg_kh2, cfg_ci, cfg_w, cfg_l, cfg_beats,
    output px_valid, px_last, px_data, px_keep, m_ready, done,
    input  cfg_ready, px_ready, m_valid, m_last, m_data, m_keep,
    input  busy, err_last, layers_done
  );
endinterface

// File: rtl/axis_pixels_sched.sv
// Layer sequencer: queued descriptor -> header beat -> N forwarded pixel beats -> wait for shifter done.
// Header 2 cycles after a push into an idle block; DATA is a zero-latency pass-through that honours m_ready.
module axis_pixels_sched #(
  parameter int S_WIDTH        = 128,
  parameter int WORD_WIDTH     = 8,
  parameter int BITS_KH2       = 2,
  parameter int BITS_CI        = 10,
  parameter int BITS_XW        = 9,
  parameter int BITS_IM_BLOCKS = 5,
  parameter int BITS_BEATS     = 20,
  parameter int DESC_DEPTH     = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  axis_pixels_sched_if.slave  bus
);
  localparam int HDR_W = BITS_KH2 + BITS_CI + BITS_XW + BITS_IM_BLOCKS;
  localparam int PTR_W = $clog2(DESC_DEPTH);

  if (HDR_W > S_WIDTH) begin : g_hdr_too_wide
    $error("axis_pixels_sched: header fields do not fit in S_WIDTH");
  end
  if (DESC_DEPTH < 2 || (DESC_DEPTH & (DESC_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_pixels_sched: DESC_DEPTH must be a power of 2 and at least 2");
  end
  if (S_WIDTH % WORD_WIDTH != 0) begin : g_bad_word
    $error("axis_pixels_sched: S_WIDTH must be a multiple of WORD_WIDTH");
  end

  typedef struct packed {
    logic [BITS_BEATS-1:0]     beats;
    logic [BITS_IM_BLOCKS-1:0] l;
    logic [BITS_XW-1:0]        w;
    logic [BITS_CI-1:0]        ci;
    logic [BITS_KH2-1:0]       kh2;
  } desc_t;

  typedef enum logic [1:0] {IDLE, HDR, DATA, DRAIN} state_t;

  desc_t                 mem [DESC_DEPTH];
  desc_t                 head;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count, count_nxt;
  logic                  cfg_ready_q;
  state_t                state;
  logic [HDR_W-1:0]      hdr_q;
  logic [BITS_BEATS-1:0] cnt;
  logic                  done_pend, err_q, busy_q;
  logic [15:0]           layers_q;
  logic                  push, pop, last_beat, beat;

  assign push      = bus.cfg_valid & cfg_ready_q;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = mem[rd_ptr];
  assign last_beat = (cnt == BITS_BEATS'(1));
  assign beat      = (state == DATA) & bus.px_valid & bus.m_ready;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + (PTR_W + 1)'(1);
    else if (!push && pop)
      count_nxt = count - (PTR_W + 1)'(1);
  end

  always_ff @(posedge aclk) begin
    if (push)
      mem[wr_ptr] <= '{beats: bus.cfg_beats, l: bus.cfg_l, w: bus.cfg_w,
                       ci: bus.cfg_ci, kh2: bus.cfg_kh2};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cfg_ready_q <= 1'b1;
      hdr_q       <= '0;
      cnt         <= '0;
      done_pend   <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      layers_q    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_nxt;
      // Registered from the next occupancy so the pop never reaches cfg_ready combinationally.
      cfg_ready_q <= (count_nxt != (PTR_W + 1)'(DESC_DEPTH));
      if (beat && (bus.px_last != last_beat))
        err_q <= 1'b1;

      case (state)
        IDLE: if (pop) begin
          hdr_q  <= {head.l, head.w, head.ci, head.kh2};
          cnt    <= (head.beats == '0) ? BITS_BEATS'(1) : head.beats;
          state  <= HDR;
          busy_q <= 1'b1;
        end
        HDR: begin
          if (bus.done)
            done_pend <= 1'b1;
          if (bus.m_ready)
            state <= DATA;
        end
        DATA: begin
          // A done coinciding with the final beat is remembered so DRAIN exits at once.
          if (bus.done)
            done_pend <= 1'b1;
          if (beat) begin
            cnt <= cnt - BITS_BEATS'(1);
            if (last_beat)
              state <= DRAIN;
          end
        end
        DRAIN: if (bus.done || done_pend) begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          layers_q  <= layers_q + 16'd1;
          done_pend <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.m_valid  = 1'b0;
    bus.m_last   = 1'b0;
    bus.m_data   = '0;
    bus.m_keep   = '0;
    bus.px_ready = 1'b0;
    case (state)
      HDR: begin
        bus.m_valid = 1'b1;
        bus.m_data  = S_WIDTH'(hdr_q);
        bus.m_keep  = '1;
      end
      DATA: begin
        bus.m_valid  = bus.px_valid;
        bus.px_ready = bus.m_ready;
        bus.m_data   = bus.px_data;
        bus.m_keep   = bus.px_keep;
        bus.m_last   = last_beat;
      end
      default: ;
    endcase
  end

  assign bus.cfg_ready   = cfg_ready_q;
  assign bus.busy        = busy_q;
  assign bus.err_last    = err_q;
  assign bus.layers_done = layers_q;
endmodule

// File: tb/tb_axis_pixels_sched.sv
// Directed layer scenarios with random pixel payloads, checked against a queue-based stream model.
module tb_axis_pixels_sched;
  localparam int SW = 128;
  localparam int KW = 16;

  typedef struct { int kh2; int ci; int w; int l; int beats; } layer_t;
  typedef struct { logic [SW-1:0] data; logic [KW-1:0] keep; logic last; } beat_t;
  typedef struct { logic [SW-1:0] data; logic [KW-1:0] keep; logic last; logic err; int cyc; } obs_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axis_pixels_sched_if #(.S_WIDTH(SW), .WORD_WIDTH(8), .BITS_KH2(2), .BITS_CI(10),
                         .BITS_XW(9), .BITS_IM_BLOCKS(5), .BITS_BEATS(20)) bus ();

  axis_pixels_sched #(.S_WIDTH(SW), .WORD_WIDTH(8), .BITS_KH2(2), .BITS_CI(10), .BITS_XW(9),
                      .BITS_IM_BLOCKS(5), .BITS_BEATS(20), .DESC_DEPTH(4))
    dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

  int tests = 0, fails = 0;
  int cyc = 0, last_push_cyc = 0, px_acc = 0, px_viol = 0;
  int mready_mode = 0, pxv_mode = 0, done_delay = 0, done_cnt = 0;
  beat_t  px_src[$];
  beat_t  px_hist[$];
  layer_t descs[$];
  obs_t   obs[$];

  task automatic check(input string tag, input logic [159:0] o, input logic [159:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [SW-1:0] hdr_of(input layer_t d);
    return SW'(d.kh2) | (SW'(d.ci) << 2) | (SW'(d.w) << 12) | (SW'(d.l) << 21);
  endfunction

  // One clock: observe handshakes mid-cycle, then update the stimulus just after the edge.
  task automatic tick();
    bit px_hit = 1'b0;
    @(negedge aclk);
    if (aresetn) begin
      if (bus.m_valid && bus.m_ready) begin
        obs.push_back('{bus.m_data, bus.m_keep, bus.m_last, bus.err_last, cyc});
        if (bus.m_last && done_delay == 0) bus.done = 1'b1;
        else if (bus.m_last && done_delay > 0) done_cnt = done_delay;
      end
      if (bus.px_ready && !bus.m_ready) px_viol++;
      if (bus.px_valid && bus.px_ready) begin px_acc++; px_hit = 1'b1; end
      if (bus.cfg_valid && bus.cfg_ready) last_push_cyc = cyc;
    end
    @(posedge aclk);
    #1;
    cyc++;
    bus.done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) bus.done = 1'b1;
    end
    if (aresetn && last_push_cyc == cyc - 1) bus.cfg_valid = 1'b0;
    if (px_hit) begin
      void'(px_src.pop_front());
      bus.px_valid = 1'b0;
    end
    if (!bus.px_valid && px_src.size() > 0 && (pxv_mode == 0 || $urandom_range(1, 0) == 1)) begin
      bus.px_valid = 1'b1;
      bus.px_data  = px_src[0].data;
      bus.px_keep  = px_src[0].keep;
      bus.px_last  = px_src[0].last;
    end
    case (mready_mode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = cyc[0];
      default: bus.m_ready = 1'($urandom_range(1, 0));
    endcase
  endtask

  task automatic add_px(input int n, input int last_pos);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {$urandom(), $urandom(), $urandom(), $urandom()};
      b.keep = KW'($urandom());
      b.last = (i == last_pos);
      px_src.push_back(b);
      px_hist.push_back(b);
    end
  endtask

  task automatic push(input layer_t d);
    bus.cfg_kh2   = 2'(d.kh2);
    bus.cfg_ci    = 10'(d.ci);
    bus.cfg_w     = 9'(d.w);
    bus.cfg_l     = 5'(d.l);
    bus.cfg_beats = 20'(d.beats);
    bus.cfg_valid = 1'b1;
    descs.push_back(d);
    for (int i = 0; i < 100 && bus.cfg_valid; i++) tick();
    check("push_accepted", bus.cfg_valid, 1'b0);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!bus.busy && done_cnt == 0 && px_src.size() == 0) break;
    end
    check("idle_reached", bus.busy, 1'b0);
  endtask

  // Expected shifter stream: header per layer, then max(beats,1) DMA beats in arrival order.
  task automatic check_phase(input string tag, input bit partial);
    beat_t exp[$];
    beat_t b;
    int k = 0;
    foreach (descs[i]) begin
      int n = (descs[i].beats == 0) ? 1 : descs[i].beats;
      exp.push_back('{hdr_of(descs[i]), '1, 1'b0});
      for (int j = 0; j < n; j++) begin
        b = px_hist[k++];
        exp.push_back('{b.data, b.keep, (j == n - 1)});
      end
    end
    if (!partial) begin
      check({tag, "_beats"}, obs.size(), exp.size());
      check({tag, "_px_accepted"}, px_acc, k);
    end
    for (int i = 0; i < obs.size() && i < exp.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), {obs[i].data, obs[i].keep, obs[i].last},
            {exp[i].data, exp[i].keep, exp[i].last});
    descs.delete(); px_hist.delete(); obs.delete(); px_acc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, push1, hdr_cyc;
    layer_t d;
    bus.cfg_valid = 0; bus.cfg_kh2 = 0; bus.cfg_ci = 0; bus.cfg_w = 0; bus.cfg_l = 0;
    bus.cfg_beats = 0; bus.px_valid = 0; bus.px_last = 0; bus.px_data = '0; bus.px_keep = '0;
    bus.m_ready = 0; bus.done = 0;

    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_m_last", bus.m_last, 1'b0);
    check("rst_px_ready", bus.px_ready, 1'b0);
    check("rst_cfg_ready", bus.cfg_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_err_last", bus.err_last, 1'b0);
    check("rst_layers", bus.layers_done, 16'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    bus.m_ready = 1'b1;

    // Single layer, done ten cycles after the last beat.
    done_delay = 10;
    add_px(4, 3);
    push('{1, 2, 3, 0, 4});
    push1 = last_push_cyc;
    wait_idle();
    check("single_hdr_latency", obs[0].cyc - push1, 2);
    check("single_layers", bus.layers_done, 16'd1);
    check("single_err", bus.err_last, 1'b0);
    check_phase("single", 1'b0);

    // Backpressure: m_ready toggles, DMA valid random.
    mready_mode = 1; pxv_mode = 2; done_delay = 3;
    add_px(4, 3);
    push('{1, 2, 3, 0, 4});
    wait_idle();
    check("bp_px_ready_mirror", px_viol, 0);
    check("bp_layers", bus.layers_done, 16'd2);
    check_phase("bp", 1'b0);

    // Done in the same cycle as the final beat, next layer already queued.
    mready_mode = 0; pxv_mode = 0; done_delay = 0;
    add_px(3, 2);
    add_px(2, 1);
    push('{2, 100, 200, 7, 3});
    push('{3, 5, 6, 9, 2});
    wait_idle();
    check("early_obs_count", obs.size(), 7);
    check("early_next_hdr_gap", obs[4].cyc - obs[3].cyc, 3);
    check("early_layers", bus.layers_done, 16'd4);
    check_phase("early", 1'b0);

    // DMA last arrives one beat early: generated last wins, error is sticky.
    done_delay = 3;
    add_px(3, 1);
    push('{0, 17, 33, 4, 3});
    wait_idle();
    check("mis_err_before", obs[2].err, 1'b0);
    check("mis_err_after", obs[3].err, 1'b1);
    check("mis_err_sticky", bus.err_last, 1'b1);
    check("mis_layers", bus.layers_done, 16'd5);
    check_phase("mis", 1'b0);

    // Fill the FIFO while a layer sits in DRAIN, then reset mid-layer 2.
    done_delay = -1;
    add_px(2, 1);
    push('{1, 1, 1, 1, 2});
    for (int i = 0; i < 50 && obs.size() < 3; i++) tick();
    repeat (3) tick();
    check("q_drain_busy", bus.busy, 1'b1);
    n1 = $urandom_range(3, 1);
    add_px(n1, n1 - 1);
    add_px(3, 2);
    add_px(1, 0);
    add_px(2, 1);
    d = '{$urandom_range(3, 0), $urandom_range(1023, 0), $urandom_range(511, 0), $urandom_range(31, 0), n1};
    push(d);
    push1 = last_push_cyc;
    push('{2, 222, 111, 22, 3});
    push('{3, 333, 444, 11, 0});
    push('{0, 1000, 500, 30, 2});
    check("q_back_to_back", last_push_cyc - push1, 3);
    check("q_cfg_ready_full", bus.cfg_ready, 1'b0);
    done_delay = 3;
    bus.done = 1'b1;
    tick();
    for (int i = 0; i < 100 && obs.size() < 6 + n1; i++) tick();
    check("q_reached_layer2", obs.size(), 6 + n1);
    aresetn = 1'b0;
    px_src.delete(); bus.px_valid = 1'b0; done_cnt = 0; bus.done = 1'b0;
    tick();
    check("mid_rst_m_valid", bus.m_valid, 1'b0);
    check("mid_rst_m_last", bus.m_last, 1'b0);
    check("mid_rst_px_ready", bus.px_ready, 1'b0);
    check("mid_rst_cfg_ready", bus.cfg_ready, 1'b1);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_err_last", bus.err_last, 1'b0);
    check("mid_rst_layers", bus.layers_done, 16'd0);
    aresetn = 1'b1;
    check_phase("queue", 1'b1);
    repeat (3) tick();
    check("post_rst_idle_m_valid", bus.m_valid, 1'b0);
    check("post_rst_cfg_ready", bus.cfg_ready, 1'b1);

    // Fresh layer after reset with every field at its maximum.
    add_px(2, 1);
    push('{3, 1023, 511, 31, 2});
    push1 = last_push_cyc;
    wait_idle();
    hdr_cyc = obs[0].cyc;
    check("fresh_hdr_latency", hdr_cyc - push1, 2);
    check("fresh_layers", bus.layers_done, 16'd1);
    check_phase("fresh", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axis_pixels_sched.md
# axis_pixels_sched

Layer sequencer for the pixel input path. It queues per-layer pixel descriptors and emits a header beat carrying the layer's reference fields (kh2, ci, w, l) for each layer. It then forwards exactly the descriptor's number of pixel beats from the DMA stream, generating `m_last` itself. Before starting the next layer it waits for the pixel shifter's end-of-layer pulse, so a new header never reaches the shifter while it is still draining.

## Interface
Parameters:
- `S_WIDTH`, 128: pixel stream width in bits; equals the shifter's input width.
- `WORD_WIDTH`, 8: bits per pixel word; `S_WIDTH/WORD_WIDTH` keep bits.
- `BITS_KH2`, 2: width of the kh2 field.
- `BITS_CI`, 10: width of the ci field.
- `BITS_XW`, 9: width of the w field.
- `BITS_IM_BLOCKS`, 5: width of the l field.
- `BITS_BEATS`, 20: width of the pixel-beat count.
- `DESC_DEPTH`, 4: descriptor FIFO depth; power of 2, ≥2.

Ports:
- `aclk`  in  1: clock.
- `aresetn`  in  1: reset, synchronous, active-low.
- `cfg_valid`, `cfg_ready`  in/out  1: descriptor handshake.
- `cfg_kh2`, `cfg_ci`, `cfg_w`, `cfg_l`  in  field widths: reference fields, passed verbatim into the header.
- `cfg_beats`  in  `BITS_BEATS`: pixel beats after the header; 0 is treated as 1.
- `px_valid`, `px_ready`, `px_last`  in/out/in  1: DMA pixel stream.
- `px_data`  in  `S_WIDTH`: DMA pixel data.
- `px_keep`  in  `S_WIDTH/WORD_WIDTH`: DMA pixel keep.
- `m_valid`, `m_ready`, `m_last`  out/in/out  1: stream to the pixel shifter.
- `m_data`  out  `S_WIDTH`: data to the pixel shifter.
- `m_keep`  out  `S_WIDTH/WORD_WIDTH`: keep to the pixel shifter.
- `done`  in  1: one-cycle pulse on the shifter's output last beat (`m_valid & m_ready & m_last` of the shifter).
- `busy`  out  1: high whenever the state is not IDLE.
- `err_last`  out  1: sticky; set when `px_last` disagrees with the generated last.
- `layers_done`  out  16: count of completed layers; wraps.

## Operation
- Descriptor FIFO:
  - `cfg_ready = !full`, registered, with no combinational path from the pop.
  - A push while full is impossible by construction.
  - The pop happens on the IDLE→HDR transition.
- FSM states: IDLE, HDR, DATA, DRAIN.
  - **IDLE:** when the FIFO is non-empty, pop it, latch the fields, set `cnt = max(cfg_beats,1)`, then → HDR.
  - **HDR:**
    - `m_valid=1`, `m_last=0`, `m_keep` all ones.
    - `m_data` = `{l, w, ci, kh2}` zero-extended to `S_WIDTH`, with kh2 at bit 0.
    - `px_ready=0`.
    - On `m_ready` → DATA.
  - **DATA:** combinational pass-through.
    - `m_valid=px_valid`, `px_ready=m_ready`, `m_data=px_data`, `m_keep=px_keep`.
    - `m_last = (cnt==1)`.
    - On each accepted beat, `cnt--`.
    - On the accepted beat with `cnt==1` → DRAIN.
  - **DRAIN:** `m_valid=0`, `px_ready=0`. When `done` or `done_pend` is set → IDLE, `layers_done++`, `done_pend` cleared.
- `done_pend`:
  - Set by `done` in HDR or DATA, including a `done` in the same cycle as the final DATA beat.
  - Consumed in DRAIN.
  - `done` in IDLE or DRAIN-exit cycles is otherwise ignored.
- `err_last`: on every accepted DATA beat, if `px_last != (cnt==1)` then `err_last` is set. Stream behaviour is unchanged: the generated last always wins and the extra DMA beats belong to the next layer.
- Width rule: `BITS_KH2+BITS_CI+BITS_XW+BITS_IM_BLOCKS ≤ S_WIDTH`; this is checked by an elaboration assertion.

## Timing
- Reset values:
  - outputs: `m_valid=0`, `m_last=0`, `px_ready=0`, `cfg_ready=1`, `busy=0`, `err_last=0`, `layers_done=0`.
  - internal: FIFO empty, state IDLE, `done_pend=0`.
- Reset mid-layer aborts the layer: no partial counts survive and the FIFO is flushed.
- Latency:
  - The header appears 2 cycles after a descriptor push into an empty FIFO while IDLE: FIFO write, then IDLE pop.
  - DATA adds zero latency (combinational).
  - DRAIN→IDLE→HDR costs 2 cycles between layers.
- `m_valid` is never deasserted without `m_ready` in HDR. In DATA it follows `px_valid`, and the upstream stream is AXI-compliant.
- `busy` is registered from the state.

## Test plan
- **Single layer.** Push kh2=1, ci=2, w=3, l=0, beats=4; stream 4 px beats with `px_last` on the 4th; pulse `done` 10 cycles later. Required: one header with `m_data[0+:26]` = packed fields, then 4 beats with `m_last` only on the 4th, then IDLE; `layers_done=1`, `err_last=0`.
- **Backpressure.** Same layer with `m_ready` toggling 1010…. Required: every beat delivered exactly once and in order, and `px_ready` mirrors `m_ready` in DATA.
- **Early `done`.** `done` asserted in the same cycle as the final DATA beat. Required: DRAIN exits on the next cycle and the next header starts 2 cycles later.
- **Last mismatch.** beats=3 with `px_last` on beat 2. Required: `m_last` on beat 3, `err_last` sticky from beat 2.
- **Queueing and reset.** Push 4 descriptors back-to-back. Required: `cfg_ready` falls when the FIFO is full, and headers are issued in push order. Assert `aresetn=0` mid-layer 2. Required: all outputs return to reset values and the next push after reset starts a fresh header.
